// File: rtl/seqtrig.sv
// seqtrig: multi-stage sequential trigger for debug capture (masked compare, per-stage counts).
// Latency: trigger/armed/stage/hit_count are registered; trigger is visible the cycle after the final qualifying sample.
// Backpressure: none; one sample per enabled clk. Optional inter-stage timeout via `define SEQTRIG_TIMEOUT_EN.
module seqtrig #(
   parameter int DINBITS   = 8,
   parameter int COUNTBITS = 8,
   parameter int NSTAGES   = 4,
   parameter int TIMEOUT   = 256,
   localparam int SB       = (NSTAGES > 1) ? $clog2(NSTAGES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DINBITS-1:0]   din,
   input  logic                 arm,
   input  logic                 disarm,
   input  logic                 cfg_we,
   input  logic [SB-1:0]        cfg_stage,
   input  logic [DINBITS-1:0]   cfg_value,
   input  logic [DINBITS-1:0]   cfg_mask,
   input  logic [COUNTBITS-1:0] cfg_count,
   output logic                 trigger,
   output logic                 armed,
   output logic [SB-1:0]        stage,
   output logic [COUNTBITS-1:0] hit_count
);

   // Sequencer states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_FIRED = 2'd2;

   localparam logic [SB-1:0]        LAST_STAGE = SB'(NSTAGES - 1);
   // One extra bit so that NSTAGES itself is representable for the range check.
   localparam logic [SB:0]          NUM_STAGES = (SB + 1)'(NSTAGES);
   localparam logic [COUNTBITS-1:0] CNT_ONE    = COUNTBITS'(1);

   logic [1:0]           state_q,   state_d;
   logic [SB-1:0]        stage_q,   stage_d;
   logic [COUNTBITS-1:0] hit_q,     hit_d;
   logic                 trigger_q, trigger_d;
   logic                 armed_q,   armed_d;

   logic [DINBITS-1:0]   value_q [NSTAGES];
   logic [DINBITS-1:0]   value_d [NSTAGES];
   logic [DINBITS-1:0]   mask_q  [NSTAGES];
   logic [DINBITS-1:0]   mask_d  [NSTAGES];
   logic [COUNTBITS-1:0] count_q [NSTAGES];
   logic [COUNTBITS-1:0] count_d [NSTAGES];

   logic [DINBITS-1:0]   cur_value;
   logic [DINBITS-1:0]   cur_mask;
   logic [COUNTBITS-1:0] cur_count;
   logic [COUNTBITS-1:0] eff_count;
   logic [COUNTBITS:0]   hit_inc;
   logic                 qualify;
   logic                 stage_done;
   logic                 cfg_ok;
   logic                 timer_expire;

   // Current-stage compare and completion detect, straight off the live inputs.
   always_comb begin
      cur_value  = value_q[stage_q];
      cur_mask   = mask_q[stage_q];
      cur_count  = count_q[stage_q];
      // A programmed count of zero behaves like one so a stage can never be skipped.
      eff_count  = (cur_count == '0) ? CNT_ONE : cur_count;
      qualify    = enable && (((din ^ cur_value) & cur_mask) == '0);
      // Widened by one bit; hit_q stays below eff_count so this never wraps anyway.
      hit_inc    = {1'b0, hit_q} + {{COUNTBITS{1'b0}}, 1'b1};
      stage_done = (hit_inc >= {1'b0, eff_count});
   end

   // Stage configuration is only writable while idle and for existing stages.
   always_comb begin
      cfg_ok = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_stage} < NUM_STAGES);
      for (int i = 0; i < NSTAGES; i++) begin
         value_d[i] = value_q[i];
         mask_d[i]  = mask_q[i];
         count_d[i] = count_q[i];
         if (cfg_ok && (cfg_stage == SB'(i))) begin
            value_d[i] = cfg_value;
            mask_d[i]  = cfg_mask;
            count_d[i] = cfg_count;
         end
      end
   end

   // Configuration registers; reset to match-anything, count of one.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NSTAGES; i++) begin
            value_q[i] <= '0;
            mask_q[i]  <= '0;
            count_q[i] <= CNT_ONE;
         end
      end else begin
         for (int i = 0; i < NSTAGES; i++) begin
            value_q[i] <= value_d[i];
            mask_q[i]  <= mask_d[i];
            count_q[i] <= count_d[i];
         end
      end
   end

`ifdef SEQTRIG_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer_q, timer_d;

   // Inter-stage timer: counts idle cycles past stage 0; any qualifying sample,
   // stage change, arm/disarm or the expiry itself brings it back to zero.
   always_comb begin
      timer_expire = (state_q == S_ARMED) && (stage_q != '0) && (timer_q == TMO_LAST);
      timer_d      = '0;
      if ((state_q == S_ARMED) && !disarm && !arm && (stage_q != '0)
          && !qualify && !timer_expire) begin
         timer_d = timer_q + 1'b1;
      end
   end

   // Timer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   // Without the timeout option a stage waits forever.
   always_comb begin
      timer_expire = 1'b0;
   end
`endif

   // Sequencer next state: disarm beats arm, arm beats sample processing.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      hit_d   = hit_q;
      if (disarm) begin
         state_d = S_IDLE;
         stage_d = '0;
         hit_d   = '0;
      end else if (arm) begin
         // Restart from stage 0 and drop whatever sample arrives this cycle.
         state_d = S_ARMED;
         stage_d = '0;
         hit_d   = '0;
      end else if (state_q == S_ARMED) begin
         if (qualify) begin
            if (stage_done) begin
               if (stage_q == LAST_STAGE) begin
                  // stage/hit_count freeze at their final values in FIRED.
                  state_d = S_FIRED;
               end else begin
                  stage_d = stage_q + 1'b1;
                  hit_d   = '0;
               end
            end else begin
               hit_d = hit_inc[COUNTBITS-1:0];
            end
         end else if (timer_expire) begin
            // Timed out waiting for a later stage: fall back, stay armed.
            stage_d = '0;
            hit_d   = '0;
         end
      end
      trigger_d = (state_d == S_FIRED);
      armed_d   = (state_d == S_ARMED);
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         stage_q   <= '0;
         hit_q     <= '0;
         trigger_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         hit_q     <= hit_d;
         trigger_q <= trigger_d;
         armed_q   <= armed_d;
      end
   end

   assign trigger   = trigger_q;
   assign armed     = armed_q;
   assign stage     = stage_q;
   assign hit_count = hit_q;

endmodule

// File: tb/tb_seqtrig.sv
// Bench for seqtrig: directed scenarios plus randomized traffic against a behavioural model.
// Model updates on posedge from the driven inputs; outputs compared on every negedge.
// Define SEQTRIG_TIMEOUT_EN to also exercise the inter-stage timeout with TIMEOUT=5.
module tb_seqtrig;
   localparam int NS = 4;
   localparam int TO = 5;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] din;
   logic       arm;
   logic       disarm;
   logic       cfg_we;
   logic [1:0] cfg_stage;
   logic [7:0] cfg_value;
   logic [7:0] cfg_mask;
   logic [7:0] cfg_count;
   logic       trigger;
   logic       armed;
   logic [1:0] stage;
   logic [7:0] hit_count;

   int checks   = 0;
   int failures = 0;

   seqtrig #(.DINBITS(8), .COUNTBITS(8), .NSTAGES(NS), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .din(din), .arm(arm), .disarm(disarm),
      .cfg_we(cfg_we), .cfg_stage(cfg_stage), .cfg_value(cfg_value), .cfg_mask(cfg_mask),
      .cfg_count(cfg_count), .trigger(trigger), .armed(armed), .stage(stage),
      .hit_count(hit_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: mode 0=idle 1=armed 2=fired.
   int m_mode = 0, m_stage = 0, m_hits = 0, m_idle = 0;
   int m_val [NS];
   int m_msk [NS];
   int m_cnt [NS];
   bit m_ok = 0;

   always @(posedge clk) begin : model
      int prev_mode;
      int need;
      bit q;
      prev_mode = m_mode;
      if (reset) begin
         m_mode = 0; m_stage = 0; m_hits = 0; m_idle = 0;
         for (int i = 0; i < NS; i++) begin
            m_val[i] = 0; m_msk[i] = 0; m_cnt[i] = 1;
         end
         m_ok = 1;
      end else begin
         if (disarm) begin
            m_mode = 0; m_stage = 0; m_hits = 0; m_idle = 0;
         end else if (arm) begin
            m_mode = 1; m_stage = 0; m_hits = 0; m_idle = 0;
         end else if (m_mode == 1) begin
            need = (m_cnt[m_stage] == 0) ? 1 : m_cnt[m_stage];
            q = enable && ((int'(din) & m_msk[m_stage]) == (m_val[m_stage] & m_msk[m_stage]));
            if (q) begin
               m_idle = 0;
               if (m_hits + 1 >= need) begin
                  if (m_stage == NS - 1) m_mode = 2;
                  else begin
                     m_stage = m_stage + 1;
                     m_hits = 0;
                  end
               end else begin
                  m_hits = m_hits + 1;
               end
            end
`ifdef SEQTRIG_TIMEOUT_EN
            else if (m_stage >= 1) begin
               m_idle = m_idle + 1;
               if (m_idle >= TO) begin
                  m_stage = 0; m_hits = 0; m_idle = 0;
               end
            end
`endif
         end
         if (prev_mode == 0 && cfg_we && int'(cfg_stage) < NS) begin
            m_val[cfg_stage] = cfg_value;
            m_msk[cfg_stage] = cfg_mask;
            m_cnt[cfg_stage] = cfg_count;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("trigger",   int'(trigger),   (m_mode == 2) ? 1 : 0);
         chk("armed",     int'(armed),     (m_mode == 1) ? 1 : 0);
         chk("stage",     int'(stage),     m_stage);
         chk("hit_count", int'(hit_count), m_hits);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_in();
      enable = 0; din = 0; arm = 0; disarm = 0; cfg_we = 0;
   endtask

   task automatic cfg_write(input int s, input int v, input int m, input int c);
      cfg_we = 1; cfg_stage = 2'(s); cfg_value = 8'(v); cfg_mask = 8'(m); cfg_count = 8'(c);
      tick();
      cfg_we = 0;
   endtask

   task automatic sample(input bit en, input int d);
      enable = en; din = 8'(d);
      tick();
      enable = 0;
   endtask

   task automatic pulse_arm();
      arm = 1; tick(); arm = 0;
   endtask

   task automatic pulse_disarm();
      disarm = 1; tick(); disarm = 0;
   endtask

   initial begin
      int pick;
      reset = 1; idle_in();
      cfg_stage = 0; cfg_value = 0; cfg_mask = 0; cfg_count = 0;
      tick(); tick();
      chk("rst_trigger", int'(trigger), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_stage", int'(stage), 0);
      chk("rst_hits", int'(hit_count), 0);
      reset = 0;

      // T1: default config, every enabled sample advances one stage.
      pulse_arm();
      chk("t1_armed", int'(armed), 1);
      for (int i = 1; i <= 3; i++) begin
         sample(1, $urandom_range(0, 255));
         chk("t1_stage", int'(stage), i);
      end
      sample(1, $urandom_range(0, 255));
      chk("t1_trigger", int'(trigger), 1);
      chk("t1_stage_frozen", int'(stage), 3);
      chk("t1_model_mode", m_mode, 2);
      for (int i = 0; i < 20; i++) sample(1, $urandom_range(0, 255));
      chk("t1_sticky", int'(trigger), 1);

      // T2: counted exact match, non-consecutive hits, enable gating.
      pulse_disarm();
      chk("t2_disarm_trig", int'(trigger), 0);
      cfg_write(0, 8'hA5, 8'hFF, 3);
      pulse_arm();
      sample(1, 8'hA5); chk("t2_hit1", int'(hit_count), 1);
      sample(1, 8'h00); chk("t2_nohit", int'(hit_count), 1);
      sample(0, 8'hA5); chk("t2_en0", int'(hit_count), 1);
      sample(1, 8'hA5); chk("t2_hit2", int'(hit_count), 2);
      sample(1, 8'hA5); chk("t2_adv", int'(stage), 1);
      chk("t2_adv_hits", int'(hit_count), 0);

      // T3: partial mask.
      pulse_disarm();
      cfg_write(0, 8'h30, 8'hF0, 1);
      pulse_arm();
      sample(1, 8'h4C); chk("t3_nomatch", int'(stage), 0);
      sample(1, 8'h3C); chk("t3_match", int'(stage), 1);

      // T4: arm collides with final sample; arm from FIRED; arm+disarm.
      pulse_disarm();
      cfg_write(0, 0, 0, 1);
      pulse_arm();
      for (int i = 0; i < 3; i++) sample(1, 8'h11);
      chk("t4_stage3", int'(stage), 3);
      arm = 1; enable = 1; tick(); arm = 0; enable = 0;
      chk("t4_arm_stage", int'(stage), 0);
      chk("t4_arm_trig", int'(trigger), 0);
      chk("t4_arm_armed", int'(armed), 1);
      for (int i = 0; i < 4; i++) sample(1, 8'h22);
      chk("t4_fired", int'(trigger), 1);
      pulse_arm();
      chk("t4_rearm_trig", int'(trigger), 0);
      chk("t4_rearm_armed", int'(armed), 1);
      arm = 1; disarm = 1; tick(); arm = 0; disarm = 0;
      chk("t4_both_armed", int'(armed), 0);
      chk("t4_both_trig", int'(trigger), 0);

      // T5: writes while armed are ignored; count of 0 acts as 1.
      cfg_write(1, 0, 0, 0);
      pulse_arm();
      cfg_write(0, 8'h55, 8'hFF, 5);
      sample(1, 8'h00); chk("t5_oldcfg", int'(stage), 1);
      sample(1, 8'h00); chk("t5_count0", int'(stage), 2);
      pulse_disarm();

      // Randomized traffic, checked by the per-cycle compare.
      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 499) == 0);
         arm    = ($urandom_range(0, 15) == 0);
         disarm = ($urandom_range(0, 39) == 0);
         enable = ($urandom_range(0, 9) < 7);
         pick   = $urandom_range(0, 4);
         din    = (pick == 0) ? 8'hA5 : (pick == 1) ? 8'h5A : (pick == 2) ? 8'h3C :
                  (pick == 3) ? 8'h00 : 8'($urandom_range(0, 255));
         cfg_we    = ($urandom_range(0, 5) == 0);
         cfg_stage = 2'($urandom_range(0, 3));
         pick      = $urandom_range(0, 3);
         cfg_value = (pick == 0) ? 8'hA5 : (pick == 1) ? 8'h3C : 8'($urandom_range(0, 255));
         pick      = $urandom_range(0, 3);
         cfg_mask  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : (pick == 2) ? 8'hF0 :
                     8'($urandom_range(0, 255));
         cfg_count = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
         tick();
      end
      idle_in(); reset = 0;

`ifdef SEQTRIG_TIMEOUT_EN
      // T6: timeout fallback, and a qualifying sample on the expiry cycle wins.
      reset = 1; tick(); reset = 0;
      pulse_arm();
      sample(1, 0);
      chk("t6_stage1", int'(stage), 1);
      for (int i = 0; i < 4; i++) sample(0, 0);
      chk("t6_before_expiry", int'(stage), 1);
      sample(0, 0);
      chk("t6_fallback", int'(stage), 0);
      chk("t6_still_armed", int'(armed), 1);
      sample(1, 0);
      for (int i = 0; i < 4; i++) sample(0, 0);
      sample(1, 0);
      chk("t6_sample_wins", int'(stage), 2);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
